// File: rtl/verificador_cafe_n_if.sv
// Coffee payment controller bus: coin/keypad/dispenser inputs and
// credit, dispense and change outputs.
interface verificador_cafe_n_if #(
    parameter int N_CAFES  = 4,
    parameter int W_DINERO = 6
);
    localparam int W_TIPO = (N_CAFES > 1) ? $clog2(N_CAFES) : 1;

    logic                moneda_valida;
    logic [W_DINERO-1:0] moneda;
    logic [N_CAFES-1:0]  cafe;
    logic                cancelar;
    logic                proceso_listo;
    logic [W_DINERO-1:0] credito;
    logic                iniciarProceso;
    logic [W_TIPO-1:0]   tipoCafe;
    logic [W_DINERO-1:0] vuelto;
    logic                vuelto_valido;
    logic                falta_dinero;
    logic                moneda_rechazada;
    logic                error_timeout;

    modport slave (
        input  moneda_valida, moneda, cafe, cancelar, proceso_listo,
        output credito, iniciarProceso, tipoCafe, vuelto,
        output vuelto_valido, falta_dinero, moneda_rechazada,
        output error_timeout
    );

    modport master (
        output moneda_valida, moneda, cafe, cancelar, proceso_listo,
        input  credito, iniciarProceso, tipoCafe, vuelto,
        input  vuelto_valido, falta_dinero, moneda_rechazada,
        input  error_timeout
    );
endinterface

// File: rtl/verificador_cafe_n.sv
// Sequential coffee payment controller: credit, selection, dispense, change.
// Optional dispense watchdog enabled by VERIFICADOR_TIMEOUT_EN.
module verificador_cafe_n #(
    parameter int N_CAFES  = 4,
    parameter int W_DINERO = 6,
    parameter logic [N_CAFES*W_DINERO-1:0] PRECIOS =
        {6'd7, 6'd5, 6'd4, 6'd3},
    parameter int TIMEOUT_CICLOS = 1000
) (
    input logic clk,
    input logic reset,
    verificador_cafe_n_if.slave bus
);
    localparam int W_TIPO = (N_CAFES > 1) ? $clog2(N_CAFES) : 1;

    typedef enum logic [1:0] {
        ESPERA,
        DISPENSA,
        DEVUELVE
    } estado_t;

    estado_t             estado, estado_sig;
    logic [W_DINERO-1:0] credito_q, credito_d;
    logic [W_DINERO-1:0] cambio_q, cambio_d;
    logic [W_DINERO-1:0] vuelto_q, vuelto_d;
    logic [W_TIPO-1:0]   tipo_q, tipo_d;
    logic                falta_q, falta_d;
    logic                rech_q, rech_d;
    logic [W_DINERO:0]   suma;
    logic                sel_valida;
    logic [W_TIPO-1:0]   sel_idx;
    logic [W_DINERO-1:0] sel_precio;

`ifdef VERIFICADOR_TIMEOUT_EN
    localparam int W_CNT = $clog2(TIMEOUT_CICLOS + 1);
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [W_DINERO-1:0] precio_tipo;

    always_comb begin
        precio_tipo = '0;
        for (int i = 0; i < N_CAFES; i++) begin
            if (tipo_q == W_TIPO'(i))
                precio_tipo = PRECIOS[i*W_DINERO +: W_DINERO];
        end
    end
`endif

    always_comb begin
        sel_idx    = '0;
        sel_precio = '0;
        for (int i = 0; i < N_CAFES; i++) begin
            if (bus.cafe[i]) begin
                sel_idx    = W_TIPO'(i);
                sel_precio = PRECIOS[i*W_DINERO +: W_DINERO];
            end
        end
    end

    assign sel_valida = $onehot(bus.cafe);
    // Extra carry bit detects a coin that would overflow the credit.
    assign suma = {1'b0, credito_q} + {1'b0, bus.moneda};

    always_comb begin
        estado_sig = estado;
        credito_d  = credito_q;
        cambio_d   = cambio_q;
        vuelto_d   = vuelto_q;
        tipo_d     = tipo_q;
        falta_d    = 1'b0;
        rech_d     = 1'b0;
`ifdef VERIFICADOR_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        unique case (estado)
            ESPERA: begin
                if (bus.cancelar && credito_q != '0) begin
                    estado_sig = DEVUELVE;
                    vuelto_d   = credito_q;
                    credito_d  = '0;
                    rech_d     = bus.moneda_valida;
                end else if (sel_valida) begin
                    rech_d = bus.moneda_valida;
                    if (credito_q >= sel_precio) begin
                        estado_sig = DISPENSA;
                        tipo_d     = sel_idx;
                        cambio_d   = credito_q - sel_precio;
                        credito_d  = '0;
`ifdef VERIFICADOR_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end else begin
                        falta_d = 1'b1;
                    end
                end else if (bus.moneda_valida) begin
                    if (suma[W_DINERO])
                        rech_d = 1'b1;
                    else
                        credito_d = suma[W_DINERO-1:0];
                end
            end
            DISPENSA: begin
                rech_d = bus.moneda_valida;
                if (bus.proceso_listo) begin
                    estado_sig = DEVUELVE;
                    vuelto_d   = cambio_q;
                end
`ifdef VERIFICADOR_TIMEOUT_EN
                // Watchdog expiry refunds the price along with the change.
                else if (cnt_q == W_CNT'(TIMEOUT_CICLOS - 1)) begin
                    estado_sig = DEVUELVE;
                    vuelto_d   = cambio_q + precio_tipo;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DEVUELVE: begin
                rech_d     = bus.moneda_valida;
                estado_sig = ESPERA;
            end
            default: estado_sig = ESPERA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= ESPERA;
            credito_q <= '0;
            cambio_q  <= '0;
            vuelto_q  <= '0;
            tipo_q    <= '0;
            falta_q   <= 1'b0;
            rech_q    <= 1'b0;
`ifdef VERIFICADOR_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            estado    <= estado_sig;
            credito_q <= credito_d;
            cambio_q  <= cambio_d;
            vuelto_q  <= vuelto_d;
            tipo_q    <= tipo_d;
            falta_q   <= falta_d;
            rech_q    <= rech_d;
`ifdef VERIFICADOR_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.credito          = credito_q;
    assign bus.iniciarProceso   = (estado == DISPENSA);
    assign bus.tipoCafe         = tipo_q;
    assign bus.vuelto           = vuelto_q;
    assign bus.vuelto_valido    = (estado == DEVUELVE);
    assign bus.falta_dinero     = falta_q;
    assign bus.moneda_rechazada = rech_q;
`ifdef VERIFICADOR_TIMEOUT_EN
    assign bus.error_timeout    = err_q;
`else
    assign bus.error_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_verificador_cafe_n.sv
// Directed bench for verificador_cafe_n (watchdog case built with
// VERIFICADOR_TIMEOUT_EN).
module tb_verificador_cafe_n;
`ifdef VERIFICADOR_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1000;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    verificador_cafe_n_if #(.N_CAFES(4), .W_DINERO(6)) bus ();

    verificador_cafe_n #(
        .N_CAFES(4),
        .W_DINERO(6),
        .PRECIOS({6'd7, 6'd5, 6'd4, 6'd3}),
        .TIMEOUT_CICLOS(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.moneda_valida = 1'b0;
        bus.moneda        = '0;
        bus.cafe          = '0;
        bus.cancelar      = 1'b0;
        bus.proceso_listo = 1'b0;
    endtask

    task automatic coin(input int v);
        bus.moneda_valida = 1'b1;
        bus.moneda        = 6'(v);
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_credito", int'(bus.credito), 0);
        chk("rst_inicia", int'(bus.iniciarProceso), 0);
        chk("rst_tipo", int'(bus.tipoCafe), 0);
        chk("rst_vuelto", int'(bus.vuelto), 0);
        chk("rst_vvalido", int'(bus.vuelto_valido), 0);
        chk("rst_falta", int'(bus.falta_dinero), 0);
        chk("rst_rech", int'(bus.moneda_rechazada), 0);
        chk("rst_err", int'(bus.error_timeout), 0);
        reset = 1'b0;

        // 1: exact price, zero change still strobes
        coin(2);
        chk("t1_cred2", int'(bus.credito), 2);
        coin(1);
        chk("t1_cred3", int'(bus.credito), 3);
        bus.cafe = 4'b0001;
        tick();
        idle();
        chk("t1_inicia", int'(bus.iniciarProceso), 1);
        chk("t1_tipo", int'(bus.tipoCafe), 0);
        chk("t1_cred0", int'(bus.credito), 0);
        bus.proceso_listo = 1'b1;
        tick();
        idle();
        chk("t1_vvalido", int'(bus.vuelto_valido), 1);
        chk("t1_vuelto", int'(bus.vuelto), 0);
        chk("t1_inicia0", int'(bus.iniciarProceso), 0);
        tick();
        chk("t1_vv_off", int'(bus.vuelto_valido), 0);

        // 2: insufficient then sufficient
        coin(4);
        bus.cafe = 4'b1000;
        tick();
        idle();
        chk("t2_falta", int'(bus.falta_dinero), 1);
        chk("t2_cred4", int'(bus.credito), 4);
        chk("t2_noini", int'(bus.iniciarProceso), 0);
        coin(4);
        chk("t2_falta_off", int'(bus.falta_dinero), 0);
        chk("t2_cred8", int'(bus.credito), 8);
        bus.cafe = 4'b1000;
        tick();
        idle();
        chk("t2_inicia", int'(bus.iniciarProceso), 1);
        chk("t2_tipo", int'(bus.tipoCafe), 3);
        tick();
        chk("t2_waits", int'(bus.iniciarProceso), 1);
        bus.proceso_listo = 1'b1;
        tick();
        idle();
        chk("t2_vvalido", int'(bus.vuelto_valido), 1);
        chk("t2_vuelto", int'(bus.vuelto), 1);
        tick();

        // 3: cancel beats selection
        coin(6);
        bus.cancelar = 1'b1;
        bus.cafe     = 4'b0001;
        tick();
        idle();
        chk("t3_vvalido", int'(bus.vuelto_valido), 1);
        chk("t3_vuelto", int'(bus.vuelto), 6);
        chk("t3_noini", int'(bus.iniciarProceso), 0);
        chk("t3_cred0", int'(bus.credito), 0);
        tick();
        chk("t3_idle_ini", int'(bus.iniciarProceso), 0);
        chk("t3_vuelto_hold", int'(bus.vuelto), 6);

        // cancel with no credit does nothing
        bus.cancelar = 1'b1;
        tick();
        idle();
        chk("t3_cancel0", int'(bus.vuelto_valido), 0);

        // 4: overflow and coin during dispense
        coin(60);
        chk("t4_cred60", int'(bus.credito), 60);
        coin(10);
        chk("t4_rech", int'(bus.moneda_rechazada), 1);
        chk("t4_cred_keep", int'(bus.credito), 60);
        coin(3);
        chk("t4_rech_off", int'(bus.moneda_rechazada), 0);
        chk("t4_cred63", int'(bus.credito), 63);
        bus.cafe = 4'b0001;
        tick();
        idle();
        chk("t4_inicia", int'(bus.iniciarProceso), 1);
        coin(1);
        chk("t4_rech_disp", int'(bus.moneda_rechazada), 1);
        chk("t4_cred_disp", int'(bus.credito), 0);
        bus.proceso_listo = 1'b1;
        tick();
        idle();
        chk("t4_vuelto", int'(bus.vuelto), 60);
        tick();

        // 5: multi-hot ignored; reset during dispense
        coin(10);
        bus.cafe = 4'b0110;
        tick();
        idle();
        chk("t5_noini", int'(bus.iniciarProceso), 0);
        chk("t5_nofalta", int'(bus.falta_dinero), 0);
        chk("t5_cred10", int'(bus.credito), 10);
        bus.cafe = 4'b0100;
        tick();
        idle();
        chk("t5_inicia", int'(bus.iniciarProceso), 1);
        chk("t5_tipo", int'(bus.tipoCafe), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_ini", int'(bus.iniciarProceso), 0);
        chk("t5_rst_tipo", int'(bus.tipoCafe), 0);
        chk("t5_rst_vuelto", int'(bus.vuelto), 0);
        chk("t5_rst_cred", int'(bus.credito), 0);
        tick();
        chk("t5_no_refund", int'(bus.vuelto_valido), 0);
        chk("t5_espera", int'(bus.iniciarProceso), 0);

`ifdef VERIFICADOR_TIMEOUT_EN
        // 6: watchdog refunds the full credit
        coin(9);
        bus.cafe = 4'b0100;
        tick();
        idle();
        chk("t6_inicia", int'(bus.iniciarProceso), 1);
        for (int k = 1; k < TMO; k++) begin
            tick();
            chk("t6_hold", int'(bus.iniciarProceso), 1);
            chk("t6_noerr", int'(bus.error_timeout), 0);
        end
        tick();
        chk("t6_err", int'(bus.error_timeout), 1);
        chk("t6_vvalido", int'(bus.vuelto_valido), 1);
        chk("t6_vuelto", int'(bus.vuelto), 9);
        tick();
        chk("t6_err_off", int'(bus.error_timeout), 0);
`else
        // without the watchdog, dispense waits and error stays low
        coin(5);
        bus.cafe = 4'b0100;
        tick();
        idle();
        for (int k = 0; k < 20; k++) tick();
        chk("t6_still", int'(bus.iniciarProceso), 1);
        chk("t6_noerr", int'(bus.error_timeout), 0);
        bus.proceso_listo = 1'b1;
        tick();
        idle();
        chk("t6_vuelto", int'(bus.vuelto), 0);
        chk("t6_vvalido", int'(bus.vuelto_valido), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
